// File: rtl/scoreboard_pkg.sv
// rtl/scoreboard_pkg.sv - shared types and helpers for the ID-stage hazard scoreboard
package scoreboard_pkg;

    // Widest age field an entry can carry; DEPTH must stay below 2**SB_AGE_MAX_W.
    localparam int SB_AGE_MAX_W = 4;

    localparam int REG_ZERO = 0;

    localparam logic [SB_AGE_MAX_W-1:0] FWD_GPR = '0;

    typedef struct packed {
        logic                    busy;
        logic [SB_AGE_MAX_W-1:0] age;
        logic [SB_AGE_MAX_W-1:0] ready_age;
    } sb_entry_t;

    function automatic logic [SB_AGE_MAX_W-1:0] clamp_ready_age(
        input logic [SB_AGE_MAX_W-1:0] ready_age,
        input logic [SB_AGE_MAX_W-1:0] depth
    );
        if (ready_age == '0) begin
            return SB_AGE_MAX_W'(1);
        end else if (ready_age > depth) begin
            return depth;
        end else begin
            return ready_age;
        end
    endfunction

endpackage

// File: rtl/sb_read_port.sv
// rtl/sb_read_port.sv - combinational forwarding select / hazard lookup for one read port
module sb_read_port
    import scoreboard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int REG_ID_W = $clog2(NUM_REGS),
    parameter int AGE_W    = 2
) (
    input  sb_entry_t [NUM_REGS-1:0] entries,
    input  logic [REG_ID_W-1:0]      rd_id,
    input  logic                     rd_early,
    output logic [AGE_W-1:0]         sel,
    output logic                     hazard
);

    sb_entry_t               entry;
    logic [SB_AGE_MAX_W-1:0] need;

    always_comb begin
        entry  = entries[rd_id];
        need   = '0;
        sel    = AGE_W'(FWD_GPR);
        hazard = 1'b0;
        if ((rd_id != REG_ID_W'(REG_ZERO)) && entry.busy) begin
            // An EX consumer gets one extra stage of slack over an ID consumer.
            need   = rd_early ? entry.ready_age : (entry.ready_age - SB_AGE_MAX_W'(1));
            sel    = AGE_W'(entry.age);
            hazard = (entry.age < need);
        end
    end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// rtl/id_hazard_scoreboard.sv - ID-stage register scoreboard; SB_STATS_EN adds a stall_count counter
module id_hazard_scoreboard
    import scoreboard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int NUM_READ = 2,
    parameter int DEPTH    = 3,
    parameter int REG_ID_W = $clog2(NUM_REGS),
    parameter int AGE_W    = $clog2(DEPTH + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         issue_valid,
    input  logic                         issue_wen,
    input  logic [REG_ID_W-1:0]          issue_dest,
    input  logic [AGE_W-1:0]             issue_ready_age,
    input  logic                         ex_stall,
    input  logic [NUM_READ*REG_ID_W-1:0] rd_id,
    input  logic [NUM_READ-1:0]          rd_early,
    output logic [NUM_READ*AGE_W-1:0]    rd_fwd_sel,
    output logic                         stall_out,
    output logic [NUM_REGS-1:0]          busy_vec
`ifdef SB_STATS_EN
    ,
    output logic [31:0]                  stall_count
`endif
);

    localparam logic [SB_AGE_MAX_W-1:0] DEPTH_L = SB_AGE_MAX_W'(DEPTH);

    sb_entry_t [NUM_REGS-1:0] entries_q;
    sb_entry_t [NUM_REGS-1:0] entries_d;
    logic [NUM_READ-1:0]      port_hazard;
    logic                     accept;

    always_comb begin
        entries_d = entries_q;
        accept    = issue_valid & issue_wen & ~stall_out & ~ex_stall
                    & (issue_dest != REG_ID_W'(REG_ZERO));
        if (!ex_stall) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (entries_q[i].busy) begin
                    if (entries_q[i].age == DEPTH_L) begin
                        entries_d[i] = '0;
                    end else begin
                        entries_d[i].age = entries_q[i].age + SB_AGE_MAX_W'(1);
                    end
                end
            end
        end
        // Applied last so a new writer replaces any aging/retiring entry of the same register.
        if (accept) begin
            entries_d[issue_dest].busy      = 1'b1;
            entries_d[issue_dest].age       = SB_AGE_MAX_W'(1);
            entries_d[issue_dest].ready_age =
                clamp_ready_age(SB_AGE_MAX_W'(issue_ready_age), DEPTH_L);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            entries_q <= '0;
        end else begin
            entries_q <= entries_d;
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_vec[i] = entries_q[i].busy;
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_read_port
        sb_read_port #(
            .NUM_REGS (NUM_REGS),
            .REG_ID_W (REG_ID_W),
            .AGE_W    (AGE_W)
        ) u_read_port (
            .entries  (entries_q),
            .rd_id    (rd_id[p*REG_ID_W +: REG_ID_W]),
            .rd_early (rd_early[p]),
            .sel      (rd_fwd_sel[p*AGE_W +: AGE_W]),
            .hazard   (port_hazard[p])
        );
    end

    assign stall_out = |port_hazard;

`ifdef SB_STATS_EN
    logic [31:0] stall_count_q;
    logic [31:0] stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_out && !ex_stall && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// tb/tb_id_hazard_scoreboard.sv - scoreboard-style self-checking bench for id_hazard_scoreboard
module tb_id_hazard_scoreboard;

    localparam int NUM_REGS = 32;
    localparam int NUM_READ = 2;
    localparam int DEPTH    = 3;
    localparam int REG_ID_W = 5;
    localparam int AGE_W    = 2;

    logic                         clk;
    logic                         rst_n;
    logic                         issue_valid;
    logic                         issue_wen;
    logic [REG_ID_W-1:0]          issue_dest;
    logic [AGE_W-1:0]             issue_ready_age;
    logic                         ex_stall;
    logic [NUM_READ*REG_ID_W-1:0] rd_id;
    logic [NUM_READ-1:0]          rd_early;
    logic [NUM_READ*AGE_W-1:0]    rd_fwd_sel;
    logic                         stall_out;
    logic [NUM_REGS-1:0]          busy_vec;
`ifdef SB_STATS_EN
    logic [31:0]                  stall_count;
`endif

    id_hazard_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_READ (NUM_READ),
        .DEPTH    (DEPTH)
    ) dut (
        .clock           (clk),
        .reset           (rst_n),
        .issue_valid     (issue_valid),
        .issue_wen       (issue_wen),
        .issue_dest      (issue_dest),
        .issue_ready_age (issue_ready_age),
        .ex_stall        (ex_stall),
        .rd_id           (rd_id),
        .rd_early        (rd_early),
        .rd_fwd_sel      (rd_fwd_sel),
        .stall_out       (stall_out),
        .busy_vec        (busy_vec)
`ifdef SB_STATS_EN
        ,
        .stall_count     (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  sel0;
        logic [1:0]  sel1;
        logic        stall;
        logic [31:0] busy;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: outputs are combinational, so every cycle the stimulus queued is sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, ".sel0"},  32'(rd_fwd_sel[1:0]), 32'(e.sel0));
            check({e.name, ".sel1"},  32'(rd_fwd_sel[3:2]), 32'(e.sel1));
            check({e.name, ".stall"}, 32'(stall_out),       32'(e.stall));
            check({e.name, ".busy"},  busy_vec,             e.busy);
`ifdef SB_STATS_EN
            check({e.name, ".cnt"},   stall_count,          e.cnt);
`endif
        end
    end

    task automatic step(
        input string       name,
        input logic        rstn,
        input logic        v,
        input logic [4:0]  dest,
        input logic [1:0]  ra,
        input logic        xs,
        input logic [4:0]  r0,
        input logic        e0,
        input logic [4:0]  r1,
        input logic        e1,
        input logic [1:0]  s0,
        input logic [1:0]  s1,
        input logic        st,
        input logic [31:0] busy,
        input logic [31:0] cnt
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst_n           = rstn;
        issue_valid     = v;
        issue_wen       = v;
        issue_dest      = dest;
        issue_ready_age = ra;
        ex_stall        = xs;
        rd_id           = {r1, r0};
        rd_early        = {e1, e0};
        e.name  = name;
        e.sel0  = s0;
        e.sel1  = s1;
        e.stall = st;
        e.busy  = busy;
        e.cnt   = cnt;
        exp_q.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0; issue_valid = 1'b0; issue_wen = 1'b0; issue_dest = '0;
        issue_ready_age = '0; ex_stall = 1'b0; rd_id = '0; rd_early = '0;

        //    name        rstn v  dest  ra xs r0    e0 r1    e1 s0 s1 st busy          cnt
        step("rst0",      0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 32'h0,        0);
        step("rst1",      0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 32'h0,        0);
        step("idle",      1, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 32'h0,        0);
        step("iss_r0",    1, 1, 5'd0, 2, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 32'h0,        0);
        step("r0_none",   1, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 32'h0,        0);
        // ALU r5
        step("alu_r5",    1, 1, 5'd5, 2, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 32'h0,        0);
        step("r5_a1",     1, 0, 5'd0, 0, 0, 5'd5, 0, 5'd5, 1, 1, 1, 1, 32'h20,       0);
        step("r5_a2",     1, 0, 5'd0, 0, 0, 5'd5, 0, 5'd5, 1, 2, 2, 0, 32'h20,       0);
        step("r5_a3",     1, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 32'h20,       0);
        step("r5_ret",    1, 0, 5'd0, 0, 0, 5'd5, 0, 5'd0, 0, 0, 0, 0, 32'h0,        0);
        // load r8
        step("ld_r8",     1, 1, 5'd8, 3, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 32'h0,        0);
        step("r8_a1",     1, 0, 5'd0, 0, 0, 5'd8, 0, 5'd0, 0, 1, 0, 1, 32'h100,      0);
        step("r8_a2",     1, 0, 5'd0, 0, 0, 5'd8, 0, 5'd0, 0, 2, 0, 0, 32'h100,      0);
        step("r8_a3",     1, 0, 5'd0, 0, 0, 5'd8, 0, 5'd0, 0, 3, 0, 0, 32'h100,      0);
        step("r8_ret",    1, 0, 5'd0, 0, 0, 5'd8, 0, 5'd0, 0, 0, 0, 0, 32'h0,        0);
        // WAW on r3
        step("ld_r3",     1, 1, 5'd3, 3, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 32'h0,        0);
        step("alu_r3",    1, 1, 5'd3, 2, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 32'h8,        0);
        step("r3_new",    1, 0, 5'd0, 0, 0, 5'd3, 0, 5'd0, 0, 1, 0, 0, 32'h8,        0);
        step("r3_a2",     1, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 32'h8,        0);
        step("r3_a3",     1, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 32'h8,        0);
        step("r3_ret",    1, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 32'h0,        0);
        // ex_stall freeze
        step("alu_r6",    1, 1, 5'd6, 2, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 32'h0,        0);
        step("xs_1",      1, 1, 5'd7, 2, 1, 5'd6, 0, 5'd0, 0, 1, 0, 0, 32'h40,       0);
        step("xs_2",      1, 1, 5'd7, 2, 1, 5'd6, 0, 5'd0, 0, 1, 0, 0, 32'h40,       0);
        step("xs_rel",    1, 0, 5'd0, 0, 0, 5'd6, 0, 5'd0, 0, 1, 0, 0, 32'h40,       0);
        step("xs_age2",   1, 0, 5'd0, 0, 0, 5'd6, 0, 5'd0, 0, 2, 0, 0, 32'h40,       0);
        // three writers then async reset mid-cycle
        step("ld_r10",    1, 1, 5'd10, 3, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 32'h40,      0);
        step("alu_r11",   1, 1, 5'd11, 2, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 32'h400,     0);
        step("alu_r12",   1, 1, 5'd12, 2, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 32'hC00,     0);
        step("three",     1, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 32'h1C00,     0);
        step("arst",      0, 0, 5'd0, 0, 0, 5'd11, 0, 5'd12, 0, 0, 0, 0, 32'h0,      0);
        step("arst_rel",  1, 0, 5'd0, 0, 0, 5'd11, 0, 5'd12, 0, 0, 0, 0, 32'h0,      0);
        // early-read hazards; issue under stall_out is dropped
        step("ld_r9",     1, 1, 5'd9, 3, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 32'h0,        0);
        step("r9_e1",     1, 1, 5'd14, 2, 0, 5'd0, 0, 5'd9, 1, 0, 1, 1, 32'h200,     0);
        step("r9_e2",     1, 0, 5'd0, 0, 0, 5'd0, 0, 5'd9, 1, 0, 2, 1, 32'h200,      1);
        step("r9_e3",     1, 0, 5'd0, 0, 0, 5'd0, 0, 5'd9, 1, 0, 3, 0, 32'h200,      2);
        step("ld_r13",    1, 1, 5'd13, 3, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 32'h0,       2);
        step("r13_e1",    1, 0, 5'd0, 0, 0, 5'd0, 0, 5'd13, 1, 0, 1, 1, 32'h2000,    2);
        step("r13_e2",    1, 0, 5'd0, 0, 0, 5'd0, 0, 5'd13, 1, 0, 2, 1, 32'h2000,    3);
        step("r13_e3",    1, 0, 5'd0, 0, 0, 5'd0, 0, 5'd13, 1, 0, 3, 0, 32'h2000,    4);
        step("cnt_rst",   0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 32'h0,        0);
        step("cnt_rel",   1, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 32'h0,        0);
        // ready_age 0 clamps to 1, so a normal read needs age>=0 and never stalls
        step("ra0_r4",    1, 1, 5'd4, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 32'h0,        0);
        step("ra0_rd",    1, 0, 5'd0, 0, 0, 5'd4, 0, 5'd4, 1, 1, 1, 0, 32'h10,       0);
        step("end",       1, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 32'h10,       0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
